// File: rtl/wb_tx_framer.sv
// wb_tx_framer: Wishbone byte slave that builds one Ethernet TX frame (payload, pad, FCS) into the TX FIFO
module wb_tx_framer #(
  parameter int LEN_W      = 11,
  parameter bit PAD_EN     = 1'b1,
  parameter int MIN_LEN    = 60,
  parameter bit IRQ_EN_RST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [2:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stall,
  output logic [7:0] o_wb_data,
  input  logic       i_fifo_full,
  output logic       o_fifo_wr,
  output logic [7:0] o_fifo_data,
  output logic       o_fifo_last,
  output logic       o_fifo_abort,
  output logic       o_irq
);
  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_PAD, S_FCS_WAIT, S_FCS} state_t;
  localparam logic [LEN_W-1:0] MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, remain_q, remain_d, cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
  logic             ack_q, ack_d, wr_q, wr_d, last_q, last_d, abort_q, abort_d;
  logic             feed_q, feed_d, clr_q, clr_d;
  logic [7:0]       rdata_q, rdata_d, fdata_q, fdata_d;
  logic [31:0]      fcs;
  logic [15:0]      len_x, rem_x;
  logic             busy, acc, pad;

  assign busy         = state_q != S_IDLE;
  assign o_wb_stall   = i_fifo_full | (state_q inside {S_PAD, S_FCS_WAIT, S_FCS});
  assign acc          = i_wb_cyc & i_wb_stb & !o_wb_stall;
  assign pad          = PAD_EN && (len_q < MIN);
  assign len_x        = 16'(len_q);
  assign rem_x        = 16'(remain_q);
  assign o_wb_ack     = ack_q;
  assign o_wb_data    = rdata_q;
  assign o_fifo_wr    = wr_q;
  assign o_fifo_data  = fdata_q;
  assign o_fifo_last  = last_q;
  assign o_fifo_abort = abort_q;
  assign o_irq        = done_q & irq_en_q;

  // CRC runs one cycle behind the FIFO port, on the bytes actually written
  wb_tx_crc32 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_q),
    .en_i   (feed_q),
    .data_i (fdata_q),
    .fcs_o  (fcs)
  );

  // bus decode, frame engine and next-state logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    ack_d    = acc;
    rdata_d  = 8'h00;
    wr_d     = 1'b0;
    fdata_d  = 8'h00;
    last_d   = 1'b0;
    abort_d  = 1'b0;
    feed_d   = 1'b0;
    clr_d    = 1'b0;
    if (acc && !i_wb_we) begin
      case (i_wb_addr)
        3'd1:    rdata_d = len_x[7:0];
        3'd2:    rdata_d = len_x[15:8];
        3'd3:    rdata_d = {4'b0, irq_en_q, err_q, done_q, busy};
        3'd4:    rdata_d = rem_x[7:0];
        3'd5:    rdata_d = rem_x[15:8];
        default: rdata_d = 8'h00;
      endcase
    end
    if (acc && i_wb_we) begin
      if (!busy && i_wb_addr == 3'd1) len_d[7:0] = i_wb_data;
      if (!busy && i_wb_addr == 3'd2) len_d[LEN_W-1:8] = i_wb_data[LEN_W-9:0];
      if (i_wb_addr == 3'd0 && !busy) err_d = 1'b1;
      if (i_wb_addr == 3'd0 && busy) begin
        wr_d     = 1'b1;
        fdata_d  = i_wb_data;
        feed_d   = 1'b1;
        remain_d = remain_q - ONE;
        if (remain_q == ONE) begin
          state_d = pad ? S_PAD : S_FCS_WAIT;
          cnt_d   = pad ? MIN - len_q : '0;
        end
      end
      if (i_wb_addr == 3'd3) begin
        irq_en_d = i_wb_data[2];
        if (i_wb_data[3]) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
        if (busy && i_wb_data[1]) begin
          abort_d  = 1'b1;
          err_d    = 1'b1;
          remain_d = '0;
          state_d  = S_IDLE;
        end else if (!busy && i_wb_data[0] && len_q == '0) begin
          err_d = 1'b1;
        end else if (!busy && i_wb_data[0]) begin
          remain_d = len_q;
          done_d   = 1'b0;
          clr_d    = 1'b1;
          state_d  = S_PAYLOAD;
        end
      end
    end
    if (state_q == S_PAD && !i_fifo_full) begin
      wr_d   = 1'b1;
      feed_d = 1'b1;
      cnt_d  = cnt_q - ONE;
      if (cnt_q == ONE) state_d = S_FCS_WAIT;
    end
    if (state_q == S_FCS_WAIT) begin
      cnt_d   = cnt_q[0] ? '0 : cnt_q + ONE;
      state_d = cnt_q[0] ? S_FCS : S_FCS_WAIT;
    end
    if (state_q == S_FCS && !i_fifo_full) begin
      wr_d    = 1'b1;
      fdata_d = 8'(fcs >> {cnt_q[1:0], 3'b000});
      cnt_d   = cnt_q + ONE;
      if (cnt_q[1:0] == 2'd3) begin
        last_d  = 1'b1;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= IRQ_EN_RST;
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      wr_q     <= 1'b0;
      fdata_q  <= 8'h00;
      last_q   <= 1'b0;
      abort_q  <= 1'b0;
      feed_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      fdata_q  <= fdata_d;
      last_q   <= last_d;
      abort_q  <= abort_d;
      feed_q   <= feed_d;
      clr_q    <= clr_d;
    end
  end
endmodule

module wb_tx_crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] fcs_o
);
  logic [31:0] crc_q, crc_d;

  assign fcs_o = ~crc_q;

  // reflected CRC-32 (poly 0xEDB88320), one byte per enabled cycle
  always_comb begin
    crc_d = crc_q ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB88320) : (crc_d >> 1);
    crc_d = clr_i ? 32'hFFFFFFFF : en_i ? crc_d : crc_q;
  end

  // CRC accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= 32'hFFFFFFFF;
    else crc_q <= crc_d;
  end
endmodule

// File: tb/tb_wb_tx_framer.sv
// tb_wb_tx_framer: directed self-checking bench for wb_tx_framer (no-pad and pad instances)
module tb_wb_tx_framer;
  logic       clk = 1'b0, rst = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0, full = 1'b0, sel = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdat = 8'h00;
  logic       ack0, ack1, stall0, stall1, wr0, wr1, last0, last1, ab0, ab1, irq0, irq1;
  logic [7:0] rd0, rd1, fd0, fd1;
  logic       ack, stall, fwr, flast, fab, irq;
  logic [7:0] rdat, fdat;
  logic [8:0] qd[$];
  int         qc[$];
  int         checks = 0, errors = 0, cyc_n = 0, ab_n = 0;
  logic       prev_full = 1'b0;
  logic [7:0] dummy;
  logic [31:0] crc;

  always #5 clk = ~clk;

  wb_tx_framer #(.PAD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc & !sel), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .o_wb_ack(ack0), .o_wb_stall(stall0), .o_wb_data(rd0), .i_fifo_full(full),
    .o_fifo_wr(wr0), .o_fifo_data(fd0), .o_fifo_last(last0), .o_fifo_abort(ab0), .o_irq(irq0)
  );
  wb_tx_framer #(.PAD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc & sel), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .o_wb_ack(ack1), .o_wb_stall(stall1), .o_wb_data(rd1), .i_fifo_full(full),
    .o_fifo_wr(wr1), .o_fifo_data(fd1), .o_fifo_last(last1), .o_fifo_abort(ab1), .o_irq(irq1)
  );

  assign ack   = sel ? ack1 : ack0;
  assign stall = sel ? stall1 : stall0;
  assign rdat  = sel ? rd1 : rd0;
  assign fwr   = sel ? wr1 : wr0;
  assign fdat  = sel ? fd1 : fd0;
  assign flast = sel ? last1 : last0;
  assign fab   = sel ? ab1 : ab0;
  assign irq   = sel ? irq1 : irq0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (fwr) begin
      chk("fifo_guard", {31'b0, prev_full}, 32'd0);
      qd.push_back({flast, fdat});
      qc.push_back(cyc_n);
    end
    if (fab) ab_n++;
    prev_full = full;
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic wb(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] r);
    int n;
    n = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
    @(negedge clk);
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("stall_bound", n, 0);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack", {31'b0, ack}, 32'd1);
    r = rdat;
    cyc = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wb(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] r;
    wb(1'b0, a, 8'h00, r);
    chk(tag, {24'b0, r}, {24'b0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while (qd.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("wait_q", {31'b0, qd.size() >= n}, 32'd1);
  endtask

  task automatic hold_full(input string tag);
    @(posedge clk); #1;
    full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk(tag, {31'b0, stall}, 32'd1);
    end
    @(posedge clk); #1;
    full = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp9[13];
    logic [7:0] pl[4];
    int nz;
    exp9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    #1 rst = 1'b1;
    #2;
    chk("rst_out0", {ack0, stall0, rd0, wr0, fd0, last0, ab0, irq0}, 32'd0);
    chk("rst_out1", {ack1, stall1, rd1, wr1, fd1, last1, ab1, irq1}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd_chk("rst_status", 3'd3, 8'h00);
    rd_chk("rst_len_lo", 3'd1, 8'h00);
    // normal frame with mid-payload and mid-FCS backpressure
    sel = 1'b0;
    qd.delete(); qc.delete();
    wr(3'd1, 8'd9);
    wr(3'd2, 8'd0);
    wr(3'd3, 8'h01);
    for (int i = 0; i < 4; i++) wr(3'd0, exp9[i]);
    hold_full("bp_stall_payload");
    for (int i = 4; i < 9; i++) wr(3'd0, exp9[i]);
    wait_q(10);
    hold_full("bp_stall_fcs");
    wait_q(13);
    idle(5);
    chk("t1_count", qd.size(), 13);
    for (int i = 0; i < 13 && i < qd.size(); i++) chk($sformatf("t1_byte%0d", i), {23'b0, qd[i]}, {23'b0, i == 12, exp9[i]});
    if (qc.size() > 9) chk("t1_fcs_gap", qc[9] - qc[8], 3);
    rd_chk("t1_status", 3'd3, 8'h02);
    chk("t1_irq_off", {31'b0, irq}, 32'd0);
    wr(3'd3, 8'h04);
    chk("t1_irq_on", {31'b0, irq}, 32'd1);
    rd_chk("t1_status_irq", 3'd3, 8'h0A);
    wr(3'd3, 8'h0C);
    chk("t1_irq_clr", {31'b0, irq}, 32'd0);
    rd_chk("t1_status_clr", 3'd3, 8'h08);
    // short frame padded to MIN_LEN
    sel = 1'b1;
    qd.delete(); qc.delete();
    wr(3'd1, 8'd4);
    wr(3'd2, 8'd0);
    wr(3'd3, 8'h01);
    for (int i = 0; i < 4; i++) wr(3'd0, pl[i]);
    wait_q(64);
    idle(10);
    chk("t2_count", qd.size(), 64);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) crc = crc_upd(crc, pl[i]);
    for (int i = 0; i < 56; i++) crc = crc_upd(crc, 8'h00);
    crc = ~crc;
    if (qd.size() == 64) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t2_pay%0d", i), {23'b0, qd[i]}, {24'b0, pl[i]});
      nz = 0;
      for (int i = 4; i < 60; i++) if (qd[i] != 9'h000) nz++;
      chk("t2_pad_nonzero", nz, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_fcs%0d", i), {23'b0, qd[60+i]}, {23'b0, i == 3, crc[8*i +: 8]});
      chk("t2_fcs_gap", qc[60] - qc[59], 3);
    end
    rd_chk("t2_status", 3'd3, 8'h02);
    // abort mid-payload
    qd.delete(); qc.delete();
    wr(3'd1, 8'd20);
    wr(3'd3, 8'h01);
    for (int i = 0; i < 7; i++) wr(3'd0, 8'h40 + 8'(i));
    rd_chk("t3_remain_mid", 3'd4, 8'd13);
    ab_n = 0;
    wr(3'd3, 8'h02);
    idle(3);
    chk("t3_abort_pulses", ab_n, 1);
    chk("t3_count", qd.size(), 7);
    rd_chk("t3_status", 3'd3, 8'h04);
    rd_chk("t3_remain_lo", 3'd4, 8'h00);
    rd_chk("t3_remain_hi", 3'd5, 8'h00);
    wr(3'd0, 8'h55);
    idle(3);
    chk("t3_discard", qd.size(), 7);
    // error paths and register boundaries
    wr(3'd3, 8'h08);
    rd_chk("t4_clear", 3'd3, 8'h00);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd0);
    wr(3'd3, 8'h01);
    rd_chk("t4_start_len0", 3'd3, 8'h04);
    wr(3'd3, 8'h08);
    qd.delete(); qc.delete();
    wr(3'd0, 8'h77);
    idle(3);
    chk("t4_idle_data_nowr", qd.size(), 0);
    rd_chk("t4_idle_data_err", 3'd3, 8'h04);
    rd_chk("t4_data_reads0", 3'd0, 8'h00);
    wr(3'd2, 8'hFF);
    rd_chk("t4_len_hi_mask", 3'd2, 8'h07);
    wr(3'd1, 8'hA5);
    rd_chk("t4_len_lo", 3'd1, 8'hA5);
    // asynchronous reset during FCS
    sel = 1'b0;
    qd.delete(); qc.delete();
    wr(3'd1, 8'd9);
    wr(3'd3, 8'h01);
    for (int i = 0; i < 9; i++) wr(3'd0, exp9[i]);
    wait_q(10);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_out0", {ack0, stall0, rd0, wr0, fd0, last0, ab0, irq0}, 32'd0);
    chk("t5_rst_out1", {ack1, stall1, rd1, wr1, fd1, last1, ab1, irq1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_chk("t5_status", 3'd3, 8'h00);
    rd_chk("t5_remain_lo", 3'd4, 8'h00);
    rd_chk("t5_remain_hi", 3'd5, 8'h00);
    rd_chk("t5_len_lo", 3'd1, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_tx_framer.md
Name: wb_tx_framer

Overview:
- Byte-wide Wishbone pipelined slave that builds one complete Ethernet TX frame into the downstream TX FIFO.
- Software programs a frame length, arms the block, then streams payload bytes.
- Hardware counts the bytes, zero-pads short frames to MIN_LEN, appends the 4-byte FCS from the internal crc32 instance, and tags the final byte.
- Sits between the CPU bus and the TX FIFO/MAC, and is the successor to the fixed 8-bit word-count interface.

Parameters:
- LEN_W, 11: width of the length and remaining-count registers; LEN_W must be 9..16.
- PAD_EN, 1: 1 enables zero-padding of payload to MIN_LEN bytes.
- MIN_LEN, 60: minimum payload+pad bytes before FCS; must be below 2^LEN_W.
- IRQ_EN_RST, 0: reset value of the interrupt-enable bit.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  3  register address
- i_wb_data  in  8  write data
- o_wb_ack  out  1  registered ack
- o_wb_stall  out  1  combinational stall
- o_wb_data  out  8  registered read data
- i_fifo_full  in  1  TX FIFO full
- o_fifo_wr  out  1  FIFO write strobe
- o_fifo_data  out  8  FIFO byte
- o_fifo_last  out  1  qualifies o_fifo_wr; marks the final FCS byte
- o_fifo_abort  out  1  one-cycle pulse telling the FIFO to discard the partial frame
- o_irq  out  1  level interrupt, equal to done & irq_en

Behaviour:
- Reset: asynchronous and active-high. Clears all of the following to 0:
  - outputs
  - len, remain, done, err, state=S_IDLE
  - irq_en=IRQ_EN_RST
  - crc32 instance held in reset
- Reset mid-frame is abandoned silently; no abort pulse is generated.
- Register map:
  - 0 DATA: write only; reads return 0.
  - 1 LEN_LO: r/w.
  - 2 LEN_HI: r/w; bits [LEN_W-9:0] are used, unused bits read 0.
  - 3 CTRL/STATUS:
    - Write bit0 START, bit1 ABORT, bit2 irq_en, bit3 clear done/err (W1C).
    - Read {4'b0, irq_en, err, done, busy}.
  - 4/5 REMAIN_LO/HI: read only.
- Access, ack and stall:
  - An access is accepted when i_wb_cyc & i_wb_stb & !o_wb_stall.
  - o_wb_ack pulses exactly 1 cycle after acceptance. Read data is valid with the ack.
  - o_wb_stall = i_fifo_full | state is S_PAD, S_FCS_WAIT or S_FCS.
  - i_wb_cyc low ignores i_wb_stb.
- S_IDLE:
  - LEN writes update len.
  - A DATA write is acked, discarded, and sets err.
  - START with len==0: sets err, state unchanged.
  - START otherwise: remain<=len, done<=0, crc reset for 1 cycle, go to S_PAYLOAD.
- S_PAYLOAD:
  - Each DATA write does o_fifo_wr=1, o_fifo_data=byte, feeds crc, and remain-=1, all 1 cycle after acceptance.
  - When the last byte is written (remain hits 0):
    - If PAD_EN and len<MIN_LEN, go to S_PAD.
    - Otherwise go to S_FCS_WAIT.
  - LEN writes while busy are acked and ignored.
  - START while busy is ignored.
- S_PAD:
  - Writes one 8'h00 byte per cycle in which !i_fifo_full, fed to the crc, until MIN_LEN-len pad bytes are written.
  - Then go to S_FCS_WAIT.
- S_FCS_WAIT: fixed 2 cycles so the crc covers every byte. The first FCS write occurs exactly 3 cycles after the last payload/pad write when the FIFO is not full.
- S_FCS:
  - Writes crc[7:0], [15:8], [23:16], [31:24] in that order, one per non-full cycle.
  - o_fifo_last=1 with byte 3.
  - Then done<=1 and return to S_IDLE.
- ABORT (any busy state):
  - o_fifo_abort pulses 1 cycle after acceptance.
  - Sets err, goes to S_IDLE, remain<=0, and no further FIFO writes occur.
  - Because ABORT is a bus access, it can only be accepted in S_IDLE or S_PAYLOAD.
- FIFO overflow guard: o_fifo_wr is never asserted in a cycle following a cycle with i_fifo_full=1.
  - A bus write accepted while FIFO-not-full is still committed.
  - The engine checks i_fifo_full registered-safe, i.e. it writes only when the previous cycle was not full.
- busy = state != S_IDLE.
- START and clear written together: clear applies first, then START.

Test Plan:
- Normal frame, PAD_EN=0: len=9, START, write 0x31..0x39.
  - FIFO receives those 9 bytes, then 0x26,0x39,0xF4,0xCB with last on 0xCB.
  - done=1 and STATUS reads 0x02.
- Short-frame padding, PAD_EN=1, MIN_LEN=60: len=4, write 4 bytes.
  - Exactly 56 0x00 pad bytes, then 4 FCS bytes, 64 writes total.
  - FCS matches the software CRC-32 reference model.
- Backpressure: hold i_fifo_full high for 5 cycles mid-payload and mid-FCS.
  - o_wb_stall stays high.
  - No o_fifo_wr in the cycle after any full cycle.
  - Byte order and count are unchanged.
- Abort: len=20, write 7 bytes, write CTRL=0x02.
  - o_fifo_abort 1-cycle pulse, err=1, state idle.
  - REMAIN reads 0.
  - A subsequent DATA write is discarded.
- Error paths: START with len=0 -> err=1, busy=0. DATA write while idle -> acked, no o_fifo_wr. Write CTRL=0x08 -> STATUS=0x00.
- Async reset mid-FCS: assert rst between clock edges.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, STATUS=0x00 and REMAIN=0.
